lsu_mem_master: RTL
===================

Name: lsu_mem_master

Overview:
- Load/store initiator that drives the data port of the synchronous byte-enable block RAM on behalf of the core: address, byte enables, write data and write enable.
- It takes byte/half/word load and store requests and turns them into word-aligned RAM accesses. A misaligned access that crosses a word boundary is split into two accesses.
- Load data is realigned and sign- or zero-extended before it is returned.
- Sits between the core's memory stage and the RAM's read/write port A.

Parameters:
ADDRESS_WIDTH, 32, request and RAM address width
DATA_WIDTH, 32, RAM word width; fixed at 4 bytes
ALLOW_SPLIT, 1, 1 = split word-crossing accesses into two RAM accesses; 0 = reject them with rsp_err

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; asynchronous, active-high
req_valid  input  1  request present
req_ready  output  1  high only in IDLE with rst low; request accepted on req_valid && req_ready
req_we  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = treated as word
req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  input  ADDRESS_WIDTH  byte address
req_wdata  input  DATA_WIDTH  store data, right-justified
rsp_valid  output  1  one-cycle pulse: access complete
rsp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors
rsp_err  output  1  misaligned word-crossing access rejected (ALLOW_SPLIT=0)
mem_addr  output  ADDRESS_WIDTH  word-aligned RAM address; bits [1:0] always 00
mem_be  output  4  RAM byte enables
mem_wdata  output  DATA_WIDTH  lane-aligned write data
mem_we  output  1  RAM write enable
mem_rdata  input  DATA_WIDTH  RAM read data, valid the cycle after mem_addr is presented

Behaviour:
- All mem_* and rsp_* outputs are registers. On rst they immediately clear to 0 and the state becomes IDLE.
- Definitions: n = 1, 2 or 4 bytes; off = req_addr[1:0]; split = (off + n > 4).
- Lane mapping:
  - Build a 64-bit store image = req_wdata << (8*off) and an 8-bit lane mask = ((1<<n) - 1) << off.
  - Lower half of image and mask goes to word A = {req_addr[31:2], 00}.
  - Upper half goes to word B = word A + 4. Word B wraps from 0xFFFFFFFC to 0x00000000.
- States: IDLE, ACC1, ACC2, WAIT, RESP.
- IDLE:
  - On accept, capture the request and load mem_addr = A, mem_be = low mask, mem_wdata = low image, mem_we = req_we.
  - Go to ACC1.
  - If split and ALLOW_SPLIT = 0: mem_we = 0, rsp_err = 1, go to RESP (no RAM write).
- ACC1 (RAM samples access A):
  - If split: load the word B address, high mask, high image and mem_we; go to ACC2.
  - Else if load: mem_we = 0, go to WAIT.
  - Else (store): mem_we = 0, go to RESP.
- ACC2 (RAM samples access B):
  - Capture mem_rdata into buf0, which holds word A.
  - mem_we = 0.
  - Load: go to WAIT. Store: go to RESP.
- WAIT:
  - Take combined = split ? {mem_rdata, buf0} : {32'b0, mem_rdata}.
  - Compute combined >> (8*off), truncate to n bytes, then extend per req_unsigned.
  - Register the result into rsp_rdata; go to RESP.
- RESP: rsp_valid = 1 for exactly one cycle, then go to IDLE.
- Response timing (cycle 0 = accept cycle):
  - Aligned load: rsp_valid in cycle 3.
  - Aligned store: rsp_valid in cycle 2.
  - Split load: rsp_valid in cycle 4.
  - Split store: rsp_valid in cycle 3.
  - Rejected access: rsp_valid in cycle 1.
  - The next request can be accepted in the cycle after the rsp_valid pulse.
- mem_we is high for at most one cycle per RAM word written. Loads never assert mem_we.
- req_* inputs are ignored outside IDLE.
- rsp_rdata and rsp_err hold their value until the next response is registered.
- Reset mid-operation aborts the access and produces no response. A split store reset after ACC1 leaves word A written and word B unwritten; this is accepted behaviour.

Test Plan:
- Aligned word store to 0x10 with data 0xDEADBEEF, then word load from 0x10:
  - Store: mem_be = 1111, mem_we pulses once, rsp_valid in cycle 2.
  - Load: rsp_rdata = 0xDEADBEEF, rsp_valid in cycle 3.
- Byte store 0x80 to 0x13, then byte load from 0x13:
  - Store: mem_be = 1000, mem_wdata[31:24] = 0x80.
  - Load with req_unsigned = 0: rsp_rdata = 0xFFFFFF80.
  - Load with req_unsigned = 1: rsp_rdata = 0x00000080.
- Split word store 0x11223344 to 0x0E:
  - Two writes: word 0x0C with be = 1100 and bytes 0x3344 in lanes 3:2; then word 0x10 with be = 0011 and 0x1122 in lanes 1:0.
  - A word load from 0x0E returns 0x11223344 in cycle 4.
- Split half load at 0xFFFFFFFF:
  - Second access is issued at mem_addr = 0x00000000.
  - Result = {byte0 of word 0, byte3 of word 0xFFFFFFFC}, sign-extended.
- With ALLOW_SPLIT = 0, word store to 0x06:
  - mem_we never asserts.
  - rsp_valid and rsp_err = 1 in cycle 1; rsp_rdata = 0.
- Assert rst during ACC2 of a split load:
  - All outputs clear within the reset cycle and no rsp_valid is produced.
  - req_ready = 1 after rst deasserts.
  - A following aligned load completes normally.

Source files
------------

// File: rtl/lsu_mem_master_if.sv
// Load/store request, response and RAM port A bundle for lsu_mem_master.
// master = the LSU side, slave = core plus RAM side.
interface lsu_mem_master_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [1:0]               req_size;
    logic                     req_unsigned;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0]    req_wdata;
    logic                     rsp_valid;
    logic [DATA_WIDTH-1:0]    rsp_rdata;
    logic                     rsp_err;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [3:0]               mem_be;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic                     mem_we;
    logic [DATA_WIDTH-1:0]    mem_rdata;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned,
        input  req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_be, mem_wdata, mem_we
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned,
        output req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_be, mem_wdata, mem_we
    );
endinterface

// File: rtl/lsu_mem_master.sv
// Byte/half/word load-store initiator for a byte-enable block RAM.
// Word-crossing accesses become two RAM accesses (or are rejected).
module lsu_mem_master #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ALLOW_SPLIT   = 1
) (
    input logic clk,
    input logic rst,
    lsu_mem_master_if.master bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ACC1 = 3'd1;
    localparam logic [2:0] S_ACC2 = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    logic [2:0]               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]               mem_be_q, mem_be_d;
    logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic                     mem_we_q, mem_we_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                     rsp_err_q, rsp_err_d;
    logic                     we_q, we_d;
    logic [1:0]               size_q, size_d;
    logic                     uns_q, uns_d;
    logic [1:0]               off_q, off_d;
    logic                     split_q, split_d;
    logic [3:0]               hi_be_q, hi_be_d;
    logic [DATA_WIDTH-1:0]    hi_wdata_q, hi_wdata_d;
    logic [DATA_WIDTH-1:0]    buf0_q, buf0_d;

    logic [2:0]              nbytes;
    logic [2:0]              span;
    logic                    split;
    logic [7:0]              mask;
    logic [2*DATA_WIDTH-1:0] img;
    logic [2*DATA_WIDTH-1:0] comb_w;
    logic [DATA_WIDTH-1:0]   sh;
    logic [DATA_WIDTH-1:0]   ext;

    always_comb begin
        unique case (bus.req_size)
            2'd0:    nbytes = 3'd1;
            2'd1:    nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        span  = {1'b0, bus.req_addr[1:0]} + nbytes;
        split = span > 3'd4;
        mask  = ((8'd1 << nbytes) - 8'd1) << bus.req_addr[1:0];
        img   = {{DATA_WIDTH{1'b0}}, bus.req_wdata}
                << {bus.req_addr[1:0], 3'b000};
    end

    // Realign the (possibly two-word) load and extend to full width
    always_comb begin
        comb_w = split_q ? {bus.mem_rdata, buf0_q}
                         : {{DATA_WIDTH{1'b0}}, bus.mem_rdata};
        sh = DATA_WIDTH'(comb_w >> {off_q, 3'b000});
        unique case (size_q)
            2'd0: ext = uns_q ? {24'b0, sh[7:0]}
                              : {{24{sh[7]}}, sh[7:0]};
            2'd1: ext = uns_q ? {16'b0, sh[15:0]}
                              : {{16{sh[15]}}, sh[15:0]};
            default: ext = sh;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        split_d     = split_q;
        hi_be_d     = hi_be_q;
        hi_wdata_d  = hi_wdata_q;
        buf0_d      = buf0_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d        = bus.req_we;
                    size_d      = bus.req_size;
                    uns_d       = bus.req_unsigned;
                    off_d       = bus.req_addr[1:0];
                    split_d     = split && (ALLOW_SPLIT != 0);
                    hi_be_d     = mask[7:4];
                    hi_wdata_d  = img[2*DATA_WIDTH-1:DATA_WIDTH];
                    mem_addr_d  = {bus.req_addr[ADDRESS_WIDTH-1:2], 2'b00};
                    mem_be_d    = mask[3:0];
                    mem_wdata_d = img[DATA_WIDTH-1:0];
                    mem_we_d    = bus.req_we;
                    state_d     = S_ACC1;
                    if (split && (ALLOW_SPLIT == 0)) begin
                        mem_we_d    = 1'b0;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end
                end
            end
            S_ACC1: begin
                if (split_q) begin
                    mem_addr_d  = mem_addr_q + ADDRESS_WIDTH'(4);
                    mem_be_d    = hi_be_q;
                    mem_wdata_d = hi_wdata_q;
                    mem_we_d    = we_q;
                    state_d     = S_ACC2;
                end else begin
                    mem_we_d = 1'b0;
                    if (!we_q) begin
                        state_d = S_WAIT;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b0;
                        state_d     = S_RESP;
                    end
                end
            end
            S_ACC2: begin
                // Read data of word A arrives while B is being presented
                buf0_d   = bus.mem_rdata;
                mem_we_d = 1'b0;
                if (!we_q) begin
                    state_d = S_WAIT;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = S_RESP;
                end
            end
            S_WAIT: begin
                rsp_rdata_d = ext;
                rsp_err_d   = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            we_q        <= 1'b0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            off_q       <= '0;
            split_q     <= 1'b0;
            hi_be_q     <= '0;
            hi_wdata_q  <= '0;
            buf0_q      <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            split_q     <= split_d;
            hi_be_q     <= hi_be_d;
            hi_wdata_q  <= hi_wdata_d;
            buf0_q      <= buf0_d;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE) && !rst;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
